// File: rtl/hub_pkg.sv
// Shared defaults, index/pointer types and the destination-field helper for the root hub
// crossbar.
package hub_pkg;

  localparam int unsigned DefNumChannels  = 5;
  localparam int unsigned DefChannelWidth = 64;
  localparam int unsigned DefDestWidth    = 8;
  localparam int unsigned DefFifoDepth    = 128;
  localparam int unsigned MaxChannels     = 16;
  localparam int unsigned MaxWidth        = 256;
  localparam int unsigned MaxDestWidth    = 16;

  localparam logic [DefDestWidth-1:0] DefBcastDest = 8'hFF;

  typedef logic [$clog2(DefNumChannels)-1:0] port_idx_t;
  typedef logic [$clog2(MaxChannels)-1:0]    max_port_idx_t;
  typedef logic [$clog2(DefFifoDepth)-1:0]   fifo_ptr_t;

  // Destination lives in the top dest_width bits of a width-bit word.
  function automatic logic [MaxDestWidth-1:0] dest_field(input logic [MaxWidth-1:0] word,
                                                         input int unsigned width,
                                                         input int unsigned dest_width);
    logic [MaxWidth-1:0]     shifted;
    logic [MaxDestWidth-1:0] mask;
    shifted = word >> (width - dest_width);
    mask    = MaxDestWidth'((32'd1 << dest_width) - 32'd1);
    return shifted[MaxDestWidth-1:0] & mask;
  endfunction

endpackage

// File: rtl/hub_fifo.sv
// Single-clock circular-buffer FIFO with valid/ready on both sides; DEPTH must be a power of 2
// so the pointers wrap naturally.
module hub_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = (count_q != CntW'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/hub_crossbar.sv
// Root-hub store-and-forward crossbar: per-channel input/output FIFOs, per-output round-robin
// unicast arbitration, phase-gated broadcast, and saturating drop accounting.
module hub_crossbar
  import hub_pkg::*;
#(
  parameter int unsigned               NUM_CHANNELS  = DefNumChannels,
  parameter int unsigned               CHANNEL_WIDTH = DefChannelWidth,
  parameter int unsigned               DEST_WIDTH    = DefDestWidth,
  parameter int unsigned               FIFO_DEPTH    = DefFifoDepth,
  parameter logic [DEST_WIDTH-1:0]     BCAST_DEST    = DefBcastDest
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]   rx_data,
  input  logic [NUM_CHANNELS-1:0]                 rx_valid,
  output logic [NUM_CHANNELS-1:0]                 rx_ready,
  output logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0]   tx_data,
  output logic [NUM_CHANNELS-1:0]                 tx_valid,
  input  logic [NUM_CHANNELS-1:0]                 tx_ready,
  output logic [15:0]                             drop_count
);

  localparam int unsigned N    = NUM_CHANNELS;
  localparam int unsigned W    = CHANNEL_WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned InvW = $clog2(N + 1);

  typedef logic [IdxW-1:0] idx_t;

  function automatic idx_t wrap_inc(input idx_t v);
    return (v == idx_t'(N - 1)) ? '0 : v + idx_t'(1);
  endfunction

  logic [W-1:0]          ih_data [N];
  logic [N-1:0]          ih_valid, ih_pop;
  logic [W-1:0]          op_data [N];
  logic [N-1:0]          op_push, op_ready;
  logic [DEST_WIDTH-1:0] dest    [N];

  logic [N-1:0] is_uni, is_bc, is_inv;
  logic         bc_go;
  idx_t         bc_src, bc_cur;
  logic [N-1:0] bc_others;
  logic [N-1:0] uni_gnt;
  idx_t         uni_src [N];
  idx_t         uni_cur;
  logic [InvW-1:0] inv_cnt;
  logic [16:0]     drop_sum;

  logic         phase_q, phase_d;
  idx_t         bc_ptr_q, bc_ptr_d;
  idx_t         rr_ptr_q [N];
  idx_t         rr_ptr_d [N];
  logic [15:0]  drop_q, drop_d;

  for (genvar c = 0; c < N; c++) begin : g_ch
    hub_fifo #(
      .WIDTH(W),
      .DEPTH(FIFO_DEPTH)
    ) u_in_fifo (
      .clk_i      (clk),
      .rst_ni     (reset),
      .in_data_i  (rx_data[W*c +: W]),
      .in_valid_i (rx_valid[c]),
      .in_ready_o (rx_ready[c]),
      .out_data_o (ih_data[c]),
      .out_valid_o(ih_valid[c]),
      .out_ready_i(ih_pop[c])
    );

    hub_fifo #(
      .WIDTH(W),
      .DEPTH(FIFO_DEPTH)
    ) u_out_fifo (
      .clk_i      (clk),
      .rst_ni     (reset),
      .in_data_i  (op_data[c]),
      .in_valid_i (op_push[c]),
      .in_ready_o (op_ready[c]),
      .out_data_o (tx_data[W*c +: W]),
      .out_valid_o(tx_valid[c]),
      .out_ready_i(tx_ready[c])
    );

    assign dest[c] = DEST_WIDTH'(dest_field(MaxWidth'(ih_data[c]), W, DEST_WIDTH));
  end

  // Self-addressed words are unroutable and count as drops.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      is_bc[i]  = ih_valid[i] && (dest[i] == BCAST_DEST);
      is_uni[i] = ih_valid[i] && !is_bc[i] && (32'(dest[i]) < N) &&
                  (32'(dest[i]) != 32'(i));
      is_inv[i] = ih_valid[i] && !is_bc[i] && !is_uni[i];
    end
  end

  always_comb begin
    bc_go     = 1'b0;
    bc_src    = '0;
    bc_cur    = bc_ptr_q;
    bc_others = '0;
    for (int k = 0; k < N; k++) begin
      bc_others         = op_ready;
      bc_others[bc_cur] = 1'b1;
      if (phase_q && !bc_go && is_bc[bc_cur] && (&bc_others)) begin
        bc_go  = 1'b1;
        bc_src = bc_cur;
      end
      bc_cur = wrap_inc(bc_cur);
    end
  end

  always_comb begin
    uni_gnt = '0;
    uni_cur = '0;
    for (int j = 0; j < N; j++) begin
      uni_src[j] = '0;
      uni_cur    = rr_ptr_q[j];
      for (int k = 0; k < N; k++) begin
        if (!bc_go && op_ready[j] && !uni_gnt[j] && is_uni[uni_cur] &&
            (dest[uni_cur] == DEST_WIDTH'(j))) begin
          uni_gnt[j] = 1'b1;
          uni_src[j] = uni_cur;
        end
        uni_cur = wrap_inc(uni_cur);
      end
    end
  end

  always_comb begin
    ih_pop  = is_inv;
    op_push = '0;
    for (int j = 0; j < N; j++) op_data[j] = ih_data[uni_src[j]];
    if (bc_go) begin
      ih_pop[bc_src] = 1'b1;
      for (int j = 0; j < N; j++) begin
        op_data[j] = ih_data[bc_src];
        op_push[j] = (idx_t'(j) != bc_src);
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (uni_gnt[j]) begin
          op_push[j]         = 1'b1;
          ih_pop[uni_src[j]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    phase_d  = ~phase_q;
    bc_ptr_d = bc_go ? wrap_inc(bc_src) : bc_ptr_q;
    for (int j = 0; j < N; j++) begin
      rr_ptr_d[j] = uni_gnt[j] ? wrap_inc(uni_src[j]) : rr_ptr_q[j];
    end
    inv_cnt = '0;
    for (int i = 0; i < N; i++) inv_cnt = inv_cnt + InvW'(is_inv[i]);
    drop_sum = 17'(drop_q) + 17'(inv_cnt);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= 1'b0;
      bc_ptr_q <= '0;
      drop_q   <= '0;
      for (int j = 0; j < N; j++) rr_ptr_q[j] <= '0;
    end else begin
      phase_q  <= phase_d;
      bc_ptr_q <= bc_ptr_d;
      drop_q   <= drop_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_hub_crossbar.sv
// Directed bench for hub_crossbar: a per-output expectation queue is filled as words are sent
// and drained by a monitor that compares every egress transfer.
module tb_hub_crossbar;

  localparam int N = 5;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [W*N-1:0]   rx_data = '0;
  logic [N-1:0]     rx_valid = '0;
  logic [N-1:0]     rx_ready;
  logic [W*N-1:0]   tx_data;
  logic [N-1:0]     tx_valid;
  logic [N-1:0]     tx_ready = '1;
  logic [15:0]      drop_count;

  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] mon_exp;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hub_crossbar #(
    .NUM_CHANNELS (N),
    .CHANNEL_WIDTH(W),
    .DEST_WIDTH   (8),
    .FIFO_DEPTH   (128),
    .BCAST_DEST   (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] d, input int src, input int seq);
    return {d, src[7:0], 16'hA5A5, seq[31:0]};
  endfunction

  function automatic int total();
    int t = 0;
    for (int j = 0; j < N; j++) t += exp_q[j].size();
    return t;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      for (int j = 0; j < N; j++) begin
        if (tx_valid[j] && tx_ready[j]) begin
          vectors++;
          assert (exp_q[j].size() != 0) else begin
            miscompares++;
            $error("FAIL tx%0d_unexpected: observed %h expected no word", j, tx_data[W*j +: W]);
          end
          if (exp_q[j].size() != 0) begin
            mon_exp = exp_q[j].pop_front();
            chk($sformatf("tx%0d_data", j), tx_data[W*j +: W], mon_exp);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rx_valid = '0;
    rx_data  = '0;
    tx_ready = '1;
    reset    = 1'b0;
    for (int j = 0; j < N; j++) exp_q[j].delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int t = 0; t < budget && total() != 0; t++) @(posedge clk);
    @(negedge clk);
    chk({"drain_", tag}, 64'(total()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_rx_ready", 64'(rx_ready), 64'h1F);
    chk("rst_drop", 64'(drop_count), 64'd0);
    do_reset();

    // Unicast ch1 -> 3, two-edge latency, single delivery
    @(posedge clk); #1;
    rx_data[W*1 +: W] = 64'h03AA_5555_0000_0001;
    rx_valid[1] = 1'b1;
    exp_q[3].push_back(64'h03AA_5555_0000_0001);
    @(posedge clk); #1 rx_valid = '0;
    @(negedge clk) chk("uni_after_edge0", 64'(tx_valid), 64'd0);
    @(negedge clk) chk("uni_after_edge1", 64'(tx_valid), 64'h08);
    @(negedge clk) chk("uni_after_edge2", 64'(tx_valid), 64'd0);
    chk("uni_delivered", 64'(exp_q[3].size()), 64'd0);

    // Contention: ch0..2 all stream to dest 4 -> round-robin 0,1,2,...
    do_reset();
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
        rx_data[W*c +: W] = mk(8'd4, c, s);
        exp_q[4].push_back(mk(8'd4, c, s));
      end
      rx_valid = 5'b00111;
    end
    @(posedge clk); #1 rx_valid = '0;
    drain("contention", 100);

    // Broadcast from ch2 reaches every port except 2, popped once
    do_reset();
    @(posedge clk); #1;
    rx_data[W*2 +: W] = mk(8'hFF, 2, 77);
    rx_valid[2] = 1'b1;
    for (int j = 0; j < N; j++) if (j != 2) exp_q[j].push_back(mk(8'hFF, 2, 77));
    @(posedge clk); #1 rx_valid = '0;
    drain("bcast", 20);
    repeat (5) @(posedge clk);
    chk("bcast_quiet", 64'(tx_valid), 64'd0);

    // Backpressure: 129 words to stalled port 1, side traffic to port 3
    do_reset();
    tx_ready[1] = 1'b0;
    for (int s = 0; s < 129; s++) begin
      @(posedge clk); #1;
      rx_data[W*0 +: W] = mk(8'd1, 0, s);
      exp_q[1].push_back(mk(8'd1, 0, s));
      rx_valid[0] = 1'b1;
      if (s < 10) begin
        rx_data[W*2 +: W] = mk(8'd3, 2, s);
        exp_q[3].push_back(mk(8'd3, 2, s));
        rx_valid[2] = 1'b1;
      end else begin
        rx_valid[2] = 1'b0;
      end
    end
    @(posedge clk); #1 rx_valid = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_other_port", 64'(exp_q[3].size()), 64'd0);
    chk("bp_held", 64'(exp_q[1].size()), 64'd129);
    chk("bp_tx_valid", 64'(tx_valid), 64'h02);
    chk("bp_rx_ready", 64'(rx_ready), 64'h1F);
    tx_ready[1] = 1'b1;
    drain("backpressure", 400);

    // Drops: three to dest 7 plus one self-addressed
    do_reset();
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      rx_data[W*0 +: W] = mk(8'd7, 0, s);
      rx_valid[0] = 1'b1;
      if (s == 0) begin
        rx_data[W*1 +: W] = mk(8'd1, 1, s);
        rx_valid[1] = 1'b1;
      end else begin
        rx_valid[1] = 1'b0;
      end
    end
    @(posedge clk); #1 rx_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drop_four", 64'(drop_count), 64'd4);
    chk("drop_no_tx", 64'(tx_valid), 64'd0);

    // All five channels drop in parallel, then run into saturation
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) rx_data[W*c +: W] = mk(8'd7, c, 0);
    rx_valid = '1;
    repeat (100) @(posedge clk);
    #1 rx_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drop_parallel", 64'(drop_count), 64'd504);
    @(posedge clk); #1 rx_valid = '1;
    repeat (13200) @(posedge clk);
    #1 rx_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drop_saturate", 64'(drop_count), 64'hFFFF);

    // Reset mid-stream with words parked in output FIFOs
    tx_ready = '0;
    for (int s = 0; s < 20; s++) begin
      @(posedge clk); #1;
      rx_data[W*0 +: W] = mk(8'd2, 0, s);
      rx_data[W*1 +: W] = mk(8'd3, 1, s);
      rx_valid = 5'b00011;
    end
    @(posedge clk); #1 rx_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_tx_valid", 64'(tx_valid), 64'h0C);
    @(posedge clk); #3;
    reset = 1'b0;
    for (int j = 0; j < N; j++) exp_q[j].delete();
    #1;
    chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("mid_rst_rx_ready", 64'(rx_ready), 64'h1F);
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tx_ready = '1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_empty", 64'(tx_valid), 64'd0);
    chk("post_rst_drop", 64'(drop_count), 64'd0);

    // Fresh traffic after reset still routes
    @(posedge clk); #1;
    rx_data[W*4 +: W] = mk(8'd0, 4, 9);
    rx_valid[4] = 1'b1;
    exp_q[0].push_back(mk(8'd0, 4, 9));
    @(posedge clk); #1 rx_valid = '0;
    drain("post_rst", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hub_crossbar.md
# hub_crossbar

Parametrised successor to the stage-controller root hub. A NUM_CHANNELS-port store-and-forward crossbar with one input and one output FIFO per channel, fair per-output round-robin arbitration, a broadcast mode, and drop accounting for unroutable words. It sits at the root of the FPGA tree: channel 0 is the local controller, and channels 1..NUM_CHANNELS-1 are the links to leaf FPGAs.

## Interface
- NUM_CHANNELS, 5: number of ports (2..16).
- CHANNEL_WIDTH, 64: word width.
- DEST_WIDTH, 8: destination field, carried in bits [CHANNEL_WIDTH-1 -: DEST_WIDTH].
- FIFO_DEPTH, 128: entries per FIFO; must be a power of 2, ≥2.
- BCAST_DEST, 8'hFF: destination value meaning "all channels except the source".

Ports:
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-low.
- rx_data  in  CHANNEL_WIDTH*NUM_CHANNELS  ingress words; channel i occupies [CHANNEL_WIDTH*i +: CHANNEL_WIDTH].
- rx_valid  in  NUM_CHANNELS  ingress valid.
- rx_ready  out  NUM_CHANNELS  ingress ready; high when the input FIFO is not full.
- tx_data  out  CHANNEL_WIDTH*NUM_CHANNELS  egress words.
- tx_valid  out  NUM_CHANNELS  egress valid.
- tx_ready  in  NUM_CHANNELS  egress ready.
- drop_count  out  16  saturating count of words dropped for an invalid destination.

## Operation
- Transfers on each side occur when valid and ready are both high at the rising edge. A word is never modified in flight.
- Input FIFO i head is classified as follows:
  - unicast to d if dest < NUM_CHANNELS and dest ≠ i;
  - broadcast if dest == BCAST_DEST;
  - invalid otherwise, including dest == i.
- Invalid heads are popped in the cycle they appear and are never forwarded. drop_count increments by the number of invalid pops that cycle and saturates at 16'hFFFF.
- A phase bit toggles every cycle, starting at 0 after reset.
- Unicast arbitration (every cycle unless a broadcast issues):
  - For each output j, the requesters are the unicast heads with dest j.
  - If output FIFO j is not full, the requester nearest at-or-after rr_ptr[j] (cyclically) is granted.
  - The grant pops that input and pushes output FIFO j in the same edge.
  - rr_ptr[j] then becomes grantee+1 mod NUM_CHANNELS. Without a grant, rr_ptr[j] holds.
- Broadcast (only when phase = 1):
  - The candidate is the broadcast head nearest at-or-after bc_ptr whose target output FIFOs (all except its source) are all not full.
  - If a candidate exists, it is popped and pushed into every target output FIFO in one edge. No unicast transfer happens that cycle, and bc_ptr becomes source+1.
  - If no candidate exists, that cycle falls back to unicast arbitration. bc_ptr holds.
- Broadcast heads do not take part in unicast arbitration; they wait for a phase-1 cycle. The alternation bounds broadcast starvation to 2 cycles of contention-free space and unicast starvation to 1 cycle per broadcast.
- Each output FIFO drains to tx independently under tx_ready.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all FIFOs empty;
  - tx_valid = 0, rx_ready = all 1s, drop_count = 0;
  - rr_ptr, bc_ptr and phase = 0.
- FIFO: registered. A word pushed at edge N is visible on the output (valid high) after edge N. Full and empty are exact at FIFO_DEPTH and 0.
- Push into a full FIFO is blocked, and push and pop on the same edge are allowed.
- Minimum latency is 2 edges:
  - rx accepted at edge 0;
  - crossbar move at edge 1;
  - tx_valid high after edge 1.
- Throughput: one word per output per cycle for unicast. Non-conflicting unicasts to distinct outputs move concurrently.
- A full output FIFO only stalls the inputs targeting it (no head-of-line effect beyond that input).
- Reset asserted mid-transfer discards all buffered words. No partial state survives.

## Structure
- Package hub_pkg: typedefs for port index and pointer widths (clog2 of NUM_CHANNELS and FIFO_DEPTH), the dest-field extract function, and the BCAST_DEST default.
- Sub-module hub_fifo (WIDTH, DEPTH): single-clock circular buffer with asynchronous active-low reset and valid/ready on both sides.
- The top level contains 2×NUM_CHANNELS hub_fifo instances plus arbitration and counter logic.

## Test plan
- Unicast: ch1 sends dest=3 word 64'h03AA…01 → appears once on tx[3] exactly 2 cycles later; nothing appears on other ports.
- Contention: ch0, ch1 and ch2 all stream to dest 4 with tx_ready[4]=1 → tx[4] order is 0,1,2,0,1,2…, with no input granted twice before the others.
- Broadcast: ch2 sends dest=FF with all outputs empty → the word appears on tx[0], tx[1], tx[3] and tx[4] but not tx[2], and the input pops exactly once.
- Backpressure: tx_ready[1]=0 while 129 words target ch1 → the output FIFO holds 128 and one stays at the input head. Traffic to other outputs is unaffected. Releasing tx_ready delivers all 129 in order.
- Drops: 3 words with dest=7 (NUM_CHANNELS=5) plus 1 word with dest=own index → drop_count=4 and no tx activity. Also force the counter to 16'hFFFF and confirm it saturates.
- Reset mid-stream: assert reset with FIFOs half full → tx_valid=0 immediately. After release the FIFOs are empty and drop_count=0.
